// File: rtl/icache_refill_ctrl_if.sv
// Refill controller bus: lookup-miss inputs, fill request/response handshake and
// the tag/data/valid array write port. master = controller, slave = surroundings.
interface icache_refill_ctrl_if #(
    parameter int N_WAY      = 4,
    parameter int TAG_WIDTH  = 20,
    parameter int LINE_WIDTH = 128,
    parameter int IDX_WIDTH  = 6
);
    logic                           miss_i;
    logic [TAG_WIDTH-1:0]           miss_tag_i;
    logic [IDX_WIDTH-1:0]           miss_idx_i;
    logic [N_WAY-1:0]               way_valid_bits_i;
    logic                           flush_i;
    logic                           ifill_req_valid_o;
    logic                           ifill_req_ready_i;
    logic [TAG_WIDTH+IDX_WIDTH-1:0] ifill_req_addr_o;
    logic                           ifill_resp_valid_i;
    logic [LINE_WIDTH-1:0]          ifill_resp_data_i;
    logic                           tag_we_o;
    logic                           data_we_o;
    logic                           valid_we_o;
    logic                           valid_wdata_o;
    logic [N_WAY-1:0]               way_sel_o;
    logic [IDX_WIDTH-1:0]           wr_idx_o;
    logic [TAG_WIDTH-1:0]           wr_tag_o;
    logic [LINE_WIDTH-1:0]          wr_data_o;
    logic                           busy_o;
    logic                           refill_done_o;
    logic                           flush_done_o;

    modport master (
        input  miss_i, miss_tag_i, miss_idx_i, way_valid_bits_i, flush_i,
               ifill_req_ready_i, ifill_resp_valid_i, ifill_resp_data_i,
        output ifill_req_valid_o, ifill_req_addr_o, tag_we_o, data_we_o, valid_we_o,
               valid_wdata_o, way_sel_o, wr_idx_o, wr_tag_o, wr_data_o, busy_o,
               refill_done_o, flush_done_o
    );

    modport slave (
        output miss_i, miss_tag_i, miss_idx_i, way_valid_bits_i, flush_i,
               ifill_req_ready_i, ifill_resp_valid_i, ifill_resp_data_i,
        input  ifill_req_valid_o, ifill_req_addr_o, tag_we_o, data_we_o, valid_we_o,
               valid_wdata_o, way_sel_o, wr_idx_o, wr_tag_o, wr_data_o, busy_o,
               refill_done_o, flush_done_o
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Icache writer: refills missing lines from the fill interface into a victim way and
// walks every set clearing valid bits after reset or on flush. All outputs registered.
module icache_refill_ctrl #(
    parameter int N_WAY      = 4,
    parameter int TAG_WIDTH  = 20,
    parameter int LINE_WIDTH = 128,
    parameter int IDX_WIDTH  = 6
) (
    input logic                  clk_i,
    input logic                  rst_i,
    icache_refill_ctrl_if.master bus
);
    localparam int PW = (N_WAY > 1) ? $clog2(N_WAY) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_SET = '1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, FLUSH} state_e;

    state_e                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]           rr_q, rr_d;
    logic                    pend_q, pend_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [N_WAY-1:0]        victim_q, victim_d;

    logic                    req_valid_q, req_valid_d;
    logic                    tag_we_q, tag_we_d;
    logic                    data_we_q, data_we_d;
    logic                    valid_we_q, valid_we_d;
    logic                    valid_wdata_q, valid_wdata_d;
    logic [N_WAY-1:0]        way_sel_q, way_sel_d;
    logic [IDX_WIDTH-1:0]    wr_idx_q, wr_idx_d;
    logic [TAG_WIDTH-1:0]    wr_tag_q, wr_tag_d;
    logic [LINE_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    refill_done_q, refill_done_d;
    logic                    flush_done_q, flush_done_d;

    logic [N_WAY-1:0]        free_oh, rr_oh;
    logic                    set_full, enter_flush;

    // Lowest free way wins: scan from the top so the last hit is the lowest index.
    always_comb begin
        free_oh = '0;
        for (int w = N_WAY - 1; w >= 0; w--) begin
            if (!bus.way_valid_bits_i[w]) begin
                free_oh    = '0;
                free_oh[w] = 1'b1;
            end
        end
        rr_oh        = '0;
        rr_oh[rr_q]  = 1'b1;
        set_full     = &bus.way_valid_bits_i;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_d          = rr_q;
        pend_d        = pend_q;
        tag_d         = tag_q;
        idx_d         = idx_q;
        victim_d      = victim_q;
        req_valid_d   = 1'b0;
        tag_we_d      = 1'b0;
        data_we_d     = 1'b0;
        valid_we_d    = 1'b0;
        valid_wdata_d = 1'b0;
        way_sel_d     = '0;
        wr_idx_d      = '0;
        wr_tag_d      = '0;
        wr_data_d     = '0;
        refill_done_d = 1'b0;
        flush_done_d  = 1'b0;
        enter_flush   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    enter_flush = 1'b1;
                end else if (bus.miss_i) begin
                    tag_d       = bus.miss_tag_i;
                    idx_d       = bus.miss_idx_i;
                    victim_d    = set_full ? rr_oh : free_oh;
                    if (set_full) rr_d = rr_q + PW'(1);
                    req_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // Request stays up until accepted, even if a flush arrives meanwhile.
                if (bus.flush_i) pend_d = 1'b1;
                if (bus.ifill_req_ready_i) begin
                    state_d = WAIT;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.flush_i) pend_d = 1'b1;
                if (bus.ifill_resp_valid_i) begin
                    if (pend_q) begin
                        enter_flush = 1'b1;
                    end else begin
                        tag_we_d      = 1'b1;
                        data_we_d     = 1'b1;
                        valid_we_d    = 1'b1;
                        valid_wdata_d = 1'b1;
                        way_sel_d     = victim_q;
                        wr_idx_d      = idx_q;
                        wr_tag_d      = tag_q;
                        wr_data_d     = bus.ifill_resp_data_i;
                        refill_done_d = 1'b1;
                        state_d       = WRITE;
                    end
                end
            end
            WRITE: begin
                if (pend_q) enter_flush = 1'b1;
                else        state_d     = IDLE;
            end
            FLUSH: begin
                // flush_done_q marks the last set already on the outputs.
                if (flush_done_q) begin
                    state_d = IDLE;
                end else begin
                    valid_we_d   = 1'b1;
                    way_sel_d    = '1;
                    wr_idx_d     = cnt_q;
                    flush_done_d = (cnt_q == LAST_SET);
                    cnt_d        = cnt_q + IDX_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering the walk clears set 0 immediately so it spans exactly 2**IDX_WIDTH cycles.
        if (enter_flush) begin
            state_d       = FLUSH;
            pend_d        = 1'b0;
            tag_we_d      = 1'b0;
            data_we_d     = 1'b0;
            refill_done_d = 1'b0;
            valid_we_d    = 1'b1;
            valid_wdata_d = 1'b0;
            way_sel_d     = '1;
            wr_idx_d      = '0;
            wr_tag_d      = '0;
            wr_data_d     = '0;
            flush_done_d  = (LAST_SET == '0);
            cnt_d         = IDX_WIDTH'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= FLUSH;
            cnt_q         <= '0;
            rr_q          <= '0;
            pend_q        <= 1'b0;
            tag_q         <= '0;
            idx_q         <= '0;
            victim_q      <= '0;
            req_valid_q   <= 1'b0;
            tag_we_q      <= 1'b0;
            data_we_q     <= 1'b0;
            valid_we_q    <= 1'b0;
            valid_wdata_q <= 1'b0;
            way_sel_q     <= '0;
            wr_idx_q      <= '0;
            wr_tag_q      <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            refill_done_q <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_q          <= rr_d;
            pend_q        <= pend_d;
            tag_q         <= tag_d;
            idx_q         <= idx_d;
            victim_q      <= victim_d;
            req_valid_q   <= req_valid_d;
            tag_we_q      <= tag_we_d;
            data_we_q     <= data_we_d;
            valid_we_q    <= valid_we_d;
            valid_wdata_q <= valid_wdata_d;
            way_sel_q     <= way_sel_d;
            wr_idx_q      <= wr_idx_d;
            wr_tag_q      <= wr_tag_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            refill_done_q <= refill_done_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign bus.ifill_req_valid_o = req_valid_q;
    assign bus.ifill_req_addr_o  = {tag_q, idx_q};
    assign bus.tag_we_o          = tag_we_q;
    assign bus.data_we_o         = data_we_q;
    assign bus.valid_we_o        = valid_we_q;
    assign bus.valid_wdata_o     = valid_wdata_q;
    assign bus.way_sel_o         = way_sel_q;
    assign bus.wr_idx_o          = wr_idx_q;
    assign bus.wr_tag_o          = wr_tag_q;
    assign bus.wr_data_o         = wr_data_q;
    assign bus.busy_o            = busy_q;
    assign bus.refill_done_o     = refill_done_q;
    assign bus.flush_done_o      = flush_done_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed + randomized bench for icache_refill_ctrl; victim choice comes from a
// small transaction-level model (first free way, else round-robin counter).
module tb_icache_refill_ctrl;
  localparam int NW = 4, TW = 20, LW = 128, IW = 6;
  localparam int NSETS = 1 << IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rr_model = 0;

  icache_refill_ctrl_if #(.N_WAY(NW), .TAG_WIDTH(TW), .LINE_WIDTH(LW), .IDX_WIDTH(IW)) bus ();

  icache_refill_ctrl #(.N_WAY(NW), .TAG_WIDTH(TW), .LINE_WIDTH(LW), .IDX_WIDTH(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [NW-1:0] model_victim(input logic [NW-1:0] vb);
    logic [NW-1:0] one;
    one = 1;
    for (int w = 0; w < NW; w++)
      if (!vb[w]) return one << w;
    model_victim = one << rr_model;
    rr_model = (rr_model + 1) % NW;
  endfunction

  task automatic flush_walk(input string tn, input int flush_hold, input bit miss_hold);
    bit ok;
    int done_at, waited;
    ok = 1'b1;
    done_at = -1;
    waited = 0;
    while (!bus.valid_we_o && waited < 8) begin
      tick();
      waited++;
    end
    for (int i = 0; i < NSETS; i++) begin
      if (!(bus.valid_we_o && !bus.valid_wdata_o && bus.way_sel_o == 4'hF &&
            int'(bus.wr_idx_o) == i && !bus.tag_we_o && !bus.data_we_o &&
            !bus.refill_done_o && !bus.ifill_req_valid_o && bus.busy_o))
        ok = 1'b0;
      if (bus.flush_done_o) begin
        if (done_at >= 0) ok = 1'b0;
        done_at = i;
      end
      if (i == flush_hold) bus.flush_i = 1'b0;
      if (i == NSETS - 1 && miss_hold) bus.miss_i = 1'b0;
      if (i < NSETS - 1) tick();
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $error("FAIL %s walk fields", tn); end
    checks++;
    if (done_at !== NSETS - 1) begin errors++; $error("FAIL %s flush_done pos: %0d", tn, done_at); end
    tick();
    checks++;
    if ({bus.busy_o, bus.valid_we_o, bus.flush_done_o, bus.ifill_req_valid_o} !== 4'b0000) begin
      errors++; $error("FAIL %s idle after walk", tn);
    end
  endtask

  task automatic do_miss(input string tn, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                         input logic [NW-1:0] vb, input int rdy_dly, input int rsp_dly);
    logic [NW-1:0] ev;
    logic [LW-1:0] d;
    bit ok;
    ev = model_victim(vb);
    d = {$urandom, $urandom, $urandom, $urandom};
    bus.miss_i = 1'b1;
    bus.miss_tag_i = tag;
    bus.miss_idx_i = idx;
    bus.way_valid_bits_i = vb;
    tick();
    bus.miss_i = 1'b0;
    bus.miss_tag_i = TW'($urandom);
    bus.miss_idx_i = IW'($urandom);
    bus.way_valid_bits_i = NW'($urandom);
    checks++;
    if (bus.ifill_req_valid_o !== 1'b1) begin errors++; $error("FAIL %s req_valid", tn); end
    checks++;
    if (bus.ifill_req_addr_o !== {tag, idx}) begin
      errors++; $error("FAIL %s req_addr: %0h", tn, bus.ifill_req_addr_o);
    end
    ok = 1'b1;
    repeat (rdy_dly) begin
      tick();
      if (!(bus.ifill_req_valid_o && bus.ifill_req_addr_o == {tag, idx} && !bus.tag_we_o && bus.busy_o))
        ok = 1'b0;
    end
    if (rdy_dly > 0) begin
      checks++;
      if (ok !== 1'b1) begin errors++; $error("FAIL %s req stable", tn); end
    end
    bus.ifill_req_ready_i = 1'b1;
    tick();
    bus.ifill_req_ready_i = 1'b0;
    checks++;
    if (bus.ifill_req_valid_o !== 1'b0) begin errors++; $error("FAIL %s req dropped", tn); end
    ok = 1'b1;
    repeat (rsp_dly) begin
      tick();
      if (bus.ifill_req_valid_o || bus.tag_we_o || bus.valid_we_o || !bus.busy_o) ok = 1'b0;
    end
    if (rsp_dly > 0) begin
      checks++;
      if (ok !== 1'b1) begin errors++; $error("FAIL %s wait quiet", tn); end
    end
    bus.ifill_resp_valid_i = 1'b1;
    bus.ifill_resp_data_i = d;
    tick();
    bus.ifill_resp_valid_i = 1'b0;
    bus.ifill_resp_data_i = '0;
    checks++;
    if ({bus.tag_we_o, bus.data_we_o, bus.valid_we_o, bus.valid_wdata_o, bus.refill_done_o} !== 5'b11111) begin
      errors++; $error("FAIL %s strobes", tn);
    end
    checks++;
    if (bus.way_sel_o !== ev) begin
      errors++; $error("FAIL %s way_sel: %0h expected %0h", tn, bus.way_sel_o, ev);
    end
    checks++;
    if ({bus.wr_tag_o, bus.wr_idx_o} !== {tag, idx}) begin errors++; $error("FAIL %s wr_idx/tag", tn); end
    checks++;
    if (bus.wr_data_o !== d) begin errors++; $error("FAIL %s wr_data", tn); end
    tick();
    checks++;
    if ({bus.busy_o, bus.tag_we_o, bus.data_we_o, bus.valid_we_o, bus.refill_done_o} !== 5'b00000) begin
      errors++; $error("FAIL %s done idle", tn);
    end
  endtask

  initial begin
    bus.miss_i = 1'b0;
    bus.miss_tag_i = '0;
    bus.miss_idx_i = '0;
    bus.way_valid_bits_i = '0;
    bus.flush_i = 1'b0;
    bus.ifill_req_ready_i = 1'b0;
    bus.ifill_resp_valid_i = 1'b0;
    bus.ifill_resp_data_i = '0;

    tick();
    tick();
    checks++;
    if ({bus.busy_o, bus.valid_we_o, bus.tag_we_o, bus.ifill_req_valid_o, bus.flush_done_o, bus.refill_done_o} !== 6'b000000) begin
      errors++; $error("FAIL reset outputs");
    end
    checks++;
    if (bus.way_sel_o !== 4'b0000) begin errors++; $error("FAIL reset way_sel"); end
    rst = 1'b0;
    flush_walk("boot", 0, 1'b0);

    do_miss("basic", 20'hABCDE, 6'd5, 4'b0111, 0, 3);
    for (int k = 0; k < 5; k++)
      do_miss($sformatf("full%0d", k), TW'($urandom), IW'($urandom), 4'b1111, 0, $urandom_range(0, 2));
    do_miss("ready stall", TW'($urandom), IW'($urandom), 4'b0000, 5, 1);
    for (int k = 0; k < 16; k++)
      do_miss($sformatf("rnd%0d", k), TW'($urandom), IW'($urandom), NW'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3));

    begin
      logic [NW-1:0] unused_v;
      unused_v = model_victim(4'b0011);
      bus.miss_i = 1'b1;
      bus.miss_tag_i = 20'h12345;
      bus.miss_idx_i = 6'd9;
      bus.way_valid_bits_i = 4'b0011;
      tick();
      bus.miss_i = 1'b0;
      bus.ifill_req_ready_i = 1'b1;
      tick();
      bus.ifill_req_ready_i = 1'b0;
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      bus.ifill_resp_valid_i = 1'b1;
      bus.ifill_resp_data_i = {4{32'hDEADBEEF}};
      tick();
      bus.ifill_resp_valid_i = 1'b0;
      checks++;
      if ({bus.tag_we_o, bus.data_we_o, bus.refill_done_o, bus.valid_wdata_o} !== 4'b0000) begin
        errors++; $error("FAIL flush-wait no refill write");
      end
      checks++;
      if (bus.valid_we_o !== 1'b1) begin errors++; $error("FAIL flush-wait walk starts"); end
      flush_walk("flush-wait", 0, 1'b0);
    end

    bus.miss_i = 1'b1;
    bus.miss_tag_i = TW'($urandom);
    bus.miss_idx_i = IW'($urandom);
    bus.way_valid_bits_i = 4'b1111;
    bus.flush_i = 1'b1;
    tick();
    checks++;
    if (bus.ifill_req_valid_o !== 1'b0) begin errors++; $error("FAIL miss+flush no request"); end
    checks++;
    if (bus.valid_we_o !== 1'b1) begin errors++; $error("FAIL miss+flush walk starts"); end
    flush_walk("miss+flush", 5, 1'b1);

    do_miss("post-flush", TW'($urandom), IW'($urandom), 4'b1111, 1, 2);

    begin
      logic [NW-1:0] unused_v;
      unused_v = model_victim(4'b1111);
      bus.miss_i = 1'b1;
      bus.way_valid_bits_i = 4'b1111;
      tick();
      bus.miss_i = 1'b0;
      bus.ifill_req_ready_i = 1'b1;
      tick();
      bus.ifill_req_ready_i = 1'b0;
      rst = 1'b1;
      bus.ifill_resp_valid_i = 1'b1;
      tick();
      checks++;
      if ({bus.tag_we_o, bus.data_we_o, bus.valid_we_o, bus.busy_o, bus.refill_done_o, bus.ifill_req_valid_o} !== 6'b000000) begin
        errors++; $error("FAIL mid-refill reset");
      end
      rst = 1'b0;
      bus.ifill_resp_valid_i = 1'b0;
      rr_model = 0;
      flush_walk("rst-walk", 0, 1'b0);
    end
    do_miss("rr after reset", TW'($urandom), IW'($urandom), 4'b1111, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
